// File: rtl/dlatch_bank_ser_if.sv
// Control and data bundle for the serial-capture register bank.
// master drives stimulus; slave is the register bank itself.
interface dlatch_bank_ser_if #(
    parameter int WIDTH = 8
);
    logic             en;
    logic [1:0]       mode;
    logic [WIDTH-1:0] d;
    logic             sin;
    logic             start;
    logic [WIDTH-1:0] out;
    logic             sout;
    logic             busy;
    logic             done;

    modport master (
        output en, mode, d, sin, start,
        input  out, sout, busy, done
    );

    modport slave (
        input  en, mode, d, sin, start,
        output out, sout, busy, done
    );
endinterface

// File: rtl/dlatch_bank_ser.sv
// Shift/rotate/load register bank with a WIDTH-bit LSB-first serial capture.
// Capture is a two-state FSM; done is a registered one-cycle pulse.
module dlatch_bank_ser #(
    parameter int WIDTH = 8,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input logic              clk,
    input logic              reset,
    dlatch_bank_ser_if.slave bus
);
    typedef enum logic {
        IDLE,
        CAPT
    } state_t;

    state_t           r_state;
    state_t           w_state_n;
    logic [WIDTH-1:0] r_out;
    logic [WIDTH-1:0] w_out_n;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_n;
    logic             r_done;
    logic             w_done_n;
    logic             w_last;

    assign w_last = (r_cnt == CNT_W'(WIDTH - 1));

    always_comb begin
        w_state_n = r_state;
        w_out_n   = r_out;
        w_cnt_n   = r_cnt;
        w_done_n  = 1'b0;
        unique case (r_state)
            IDLE: begin
                // start outranks any en/mode activity on the same edge
                if (bus.start) begin
                    w_state_n = CAPT;
                    w_cnt_n   = '0;
                end else if (bus.en) begin
                    unique case (bus.mode)
                        2'b00: w_out_n = r_out;
                        2'b01: w_out_n = bus.d;
                        2'b10: w_out_n = {bus.sin, r_out[WIDTH-1:1]};
                        2'b11: w_out_n = {r_out[0], r_out[WIDTH-1:1]};
                    endcase
                end
            end
            CAPT: begin
                if (bus.en) begin
                    w_out_n = {bus.sin, r_out[WIDTH-1:1]};
                    w_cnt_n = r_cnt + CNT_W'(1);
                    if (w_last) begin
                        w_state_n = IDLE;
                        w_done_n  = 1'b1;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
            r_out   <= '0;
            r_cnt   <= '0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_n;
            r_out   <= w_out_n;
            r_cnt   <= w_cnt_n;
            r_done  <= w_done_n;
        end
    end

    assign bus.out  = r_out;
    assign bus.sout = r_out[0];
    assign bus.busy = (r_state == CAPT);
    assign bus.done = r_done;
endmodule

// File: tb/tb_dlatch_bank_ser.sv
// Directed bench for dlatch_bank_ser; stimulus queues expectations,
// a monitor pops and compares them each sample point.
module tb_dlatch_bank_ser;
    localparam int W = 8;

    typedef struct {
        string      tag;
        logic       chk_out;
        logic [W-1:0] out;
        logic       busy;
        logic       done;
    } exp_t;

    logic clk;
    logic reset;
    exp_t q[$];
    int   n_chk;
    int   n_fail;
    event ev_samp;

    dlatch_bank_ser_if #(.WIDTH(W)) bus ();

    dlatch_bank_ser #(.WIDTH(W)) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cmp(input string name, input logic [W-1:0] act,
                       input logic [W-1:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    initial begin
        exp_t e;
        forever begin
            @(negedge clk or ev_samp);
            if (q.size() > 0) begin
                e = q.pop_front();
                if (e.chk_out) begin
                    cmp({e.tag, ".out"}, bus.out, e.out);
                    cmp({e.tag, ".sout"}, W'(bus.sout), W'(e.out[0]));
                end
                cmp({e.tag, ".busy"}, W'(bus.busy), W'(e.busy));
                cmp({e.tag, ".done"}, W'(bus.done), W'(e.done));
            end
        end
    end

    task automatic push(input string t, input logic c,
                        input logic [W-1:0] o, input logic b,
                        input logic dn);
        exp_t e;
        e.tag = t;
        e.chk_out = c;
        e.out = o;
        e.busy = b;
        e.done = dn;
        q.push_back(e);
    endtask

    task automatic step(input logic e, input logic [1:0] m,
                        input logic [W-1:0] dd, input logic s,
                        input logic st, input logic c,
                        input logic [W-1:0] eo, input logic eb,
                        input logic ed, input string t);
        bus.en = e;
        bus.mode = m;
        bus.d = dd;
        bus.sin = s;
        bus.start = st;
        @(posedge clk);
        #1;
        push(t, c, eo, eb, ed);
    endtask

    task automatic async_check(input string t);
        push(t, 1'b1, '0, 1'b0, 1'b0);
        #1;
        ->ev_samp;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] cap1;
        logic [7:0] capa5;
        n_chk = 0;
        n_fail = 0;
        cap1 = 8'b1000_1101;
        capa5 = 8'hA5;
        reset = 1'b0;
        bus.en = 1'b0;
        bus.mode = 2'b00;
        bus.d = '0;
        bus.sin = 1'b0;
        bus.start = 1'b0;
        #3;
        async_check("rst_init");
        @(negedge clk);
        reset = 1'b1;

        // reset from a full register, observed before any edge
        step(1, 2'b01, 8'hFF, 0, 0, 1, 8'hFF, 0, 0, "load_ff");
        @(negedge clk);
        #1;
        reset = 1'b0;
        async_check("rst_async");
        @(negedge clk);
        reset = 1'b1;

        step(1, 2'b01, 8'hA5, 0, 0, 1, 8'hA5, 0, 0, "load");
        step(1, 2'b00, 8'h00, 1, 0, 1, 8'hA5, 0, 0, "hold");
        step(0, 2'b01, 8'h3C, 1, 0, 1, 8'hA5, 0, 0, "en0");
        step(1, 2'b11, 8'h00, 0, 0, 1, 8'hD2, 0, 0, "rot");
        step(1, 2'b10, 8'h00, 1, 0, 1, 8'hE9, 0, 0, "shr");

        // plain capture; mode/d set to a load that must be ignored
        step(1, 2'b01, 8'hFF, 0, 1, 1, 8'hE9, 1, 0, "cap_start");
        for (int i = 0; i < W; i++)
            step(1, 2'b01, 8'h00, cap1[i], 0, i == W - 1, cap1,
                 i != W - 1, i == W - 1, "cap_bit");
        step(0, 2'b00, 8'h00, 0, 0, 1, cap1, 0, 0, "cap_after");

        // stalled capture with a start pulse that must be ignored
        step(1, 2'b00, 8'h00, 0, 1, 1, cap1, 1, 0, "stl_start");
        for (int i = 0; i < 4; i++)
            step(1, 2'b00, 8'h00, cap1[i], 0, 0, '0, 1, 0, "stl_bit");
        step(0, 2'b01, 8'hFF, 1, 0, 0, '0, 1, 0, "stl_hold");
        step(0, 2'b01, 8'hFF, 1, 1, 0, '0, 1, 0, "stl_hold");
        step(0, 2'b01, 8'hFF, 1, 0, 0, '0, 1, 0, "stl_hold");
        for (int i = 4; i < W; i++)
            step(1, 2'b00, 8'h00, cap1[i], i == W - 1, i == W - 1,
                 cap1, i != W - 1, i == W - 1, "stl_bit");
        // start held through completion begins a fresh capture
        step(1, 2'b00, 8'h00, 0, 1, 1, cap1, 1, 0, "restart");

        // abort after four bits
        for (int i = 0; i < 4; i++)
            step(1, 2'b00, 8'h00, 1, 0, 0, '0, 1, 0, "abt_bit");
        @(negedge clk);
        #1;
        reset = 1'b0;
        async_check("abort");
        @(negedge clk);
        reset = 1'b1;

        step(1, 2'b00, 8'h00, 0, 1, 1, 8'h00, 1, 0, "a5_start");
        for (int i = 0; i < W; i++)
            step(1, 2'b00, 8'h00, capa5[i], 0, i == W - 1, capa5,
                 i != W - 1, i == W - 1, "a5_bit");
        step(1, 2'b00, 8'h00, 0, 0, 1, 8'hA5, 0, 0, "a5_after");

        @(negedge clk);
        #1;
        cmp("queue_drain", W'(q.size()), '0);
        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/dlatch_bank_ser.md
DLATCH_BANK_SER -- requirements
Module: dlatch_bank_ser

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, register width in bits; legal range 2..64.
REQ-002 The block SHALL have a derived parameter CNT_W, default $clog2(WIDTH+1), width of the serial bit counter.
REQ-003 Port clk SHALL be an input, 1 bit wide: the single clock, rising-edge active.
REQ-004 Port reset SHALL be an input, 1 bit wide: asynchronous, active-low reset (0 = clear).
REQ-005 Port en SHALL be an input, 1 bit wide: global enable; when 0, no register or counter update occurs.
REQ-006 Port mode SHALL be an input, 2 bits wide: 00 hold, 01 parallel load, 10 shift right, 11 rotate right.
REQ-007 Port d SHALL be an input, WIDTH bits wide: parallel load data.
REQ-008 Port sin SHALL be an input, 1 bit wide: serial input for shift-right mode and serial capture.
REQ-009 Port start SHALL be an input, 1 bit wide: request to begin a WIDTH-bit serial capture.
REQ-010 Port out SHALL be an output, WIDTH bits wide: the register contents.
REQ-011 Port sout SHALL be an output, 1 bit wide: serial output, always equal to out[0].
REQ-012 Port busy SHALL be an output, 1 bit wide: high while a serial capture is in progress.
REQ-013 Port done SHALL be an output, 1 bit wide: a one-cycle pulse marking capture completion.

Function
REQ-014 The FSM SHALL have two states, IDLE and CAPT; busy SHALL equal (state == CAPT) and SHALL be decoded from the registered state only.
REQ-015 In IDLE with start=1 at a clock edge, the FSM SHALL move to CAPT and clear the counter; out SHALL be unchanged on that edge, whatever the values of en and mode (start wins).
REQ-016 In IDLE with start=0 and en=1, each edge SHALL apply mode as follows: 00 out held; 01 out <= d; 10 out <= {sin, out[WIDTH-1:1]}; 11 out <= {out[0], out[WIDTH-1:1]}.
REQ-017 In IDLE with en=0, out SHALL hold.
REQ-018 In CAPT with en=1, each edge SHALL shift sin into the MSB (out <= {sin, out[WIDTH-1:1]}) and increment the counter; mode and d SHALL be ignored.
REQ-019 In CAPT with en=0, the block SHALL stall: out, counter and state held, busy stays 1.
REQ-020 On the edge that captures the WIDTH-th bit, the FSM SHALL return to IDLE and done SHALL be 1 for exactly the next cycle.
REQ-021 The first bit captured SHALL end in out[0] and the last bit in out[WIDTH-1].
REQ-022 Capture latency SHALL be WIDTH enabled edges after the start edge.
REQ-023 start while busy=1 SHALL be ignored; no restart and no counter change.
REQ-024 start held high through completion SHALL begin a new capture on the edge after done rises (the edge where the FSM is IDLE again).
REQ-025 done SHALL never be asserted at the same time as busy.
REQ-026 The counter SHALL never exceed WIDTH and SHALL never wrap.

Reset
REQ-027 While reset=0, the block SHALL asynchronously force out=0, sout=0, busy=0, done=0, state=IDLE and counter=0, independent of clk.
REQ-028 Reset asserted mid-capture SHALL abort the capture without a done pulse and SHALL discard the partially captured bits.
REQ-029 After reset deasserts, the first rising edge SHALL operate normally from IDLE.

Verification (WIDTH=8)
REQ-030 Reset scenario: drive reset=0 between clock edges with out=FF -> out=00, busy=0 and done=0 immediately, without waiting for a clock edge.
REQ-031 Load/hold scenario: en=1, mode=01, d=A5 -> out=A5 after 1 edge; then mode=00 -> out stays A5; then en=0, mode=01, d=3C -> out stays A5.
REQ-032 Shift/rotate scenario: from out=A5, mode=11, 1 edge -> out=D2 (sout was 1, now 0); then mode=10, sin=1, 1 edge -> out=E9.
REQ-033 Capture scenario: pulse start, then sin=1,0,1,1,0,0,0,1 on 8 enabled edges -> busy=1 for 8 cycles, out=8D, done=1 for exactly 1 cycle.
REQ-034 Stall/ignore scenario: repeat the capture scenario with en=0 for 3 cycles after bit 4 and start pulsed mid-capture -> busy=1 for 11 cycles, out=8D, a single done pulse, no restart.
REQ-035 Abort scenario: reset=0 after 4 captured bits -> out=00, no done pulse; then a new capture of A5 (LSB first) -> out=A5, done pulses once.
